// File: rtl/axil_sram_slave.sv
// axil_sram_slave: AXI4-Lite slave fronting a single-port DEPTH x DATA_W SRAM
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   awvalid/awready/awaddr        write-address channel (one-entry buffer)
//   wvalid/wready/wdata/wstrb     write-data channel (one-entry buffer)
//   bvalid/bready/bresp           write-response channel
//   arvalid/arready/araddr        read-address channel
//   rvalid/rready/rdata/rresp     read-data channel
module axil_sram_slave #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_RESP} r_state_t;

    r_state_t          state_q, state_d;
    logic              aw_full, w_full, commit, aw_ok, ar_ok;
    logic [ADDR_W-1:0] aw_addr, ar_addr, aw_idx, ar_idx;
    logic [DATA_W-1:0] w_data;
    logic [BYTES-1:0]  w_strb;
    logic [DATA_W-1:0] mem [DEPTH];

    assign awready = !aw_full;
    assign wready  = !w_full;
    assign aw_idx  = aw_addr >> OFF;
    assign ar_idx  = ar_addr >> OFF;
    assign aw_ok   = aw_idx < ADDR_W'(DEPTH);
    assign ar_ok   = ar_idx < ADDR_W'(DEPTH);
    // A pending response blocks the next commit, so B never needs more than one slot.
    assign commit  = aw_full && w_full && !bvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
        end else begin
            if (awvalid && awready) begin
                aw_full <= 1'b1;
                aw_addr <= awaddr;
            end else if (commit) begin
                aw_full <= 1'b0;
            end
            if (wvalid && wready) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end else if (commit) begin
                w_full <= 1'b0;
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= aw_ok ? 2'b00 : 2'b10;
            end else if (bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && aw_ok)
            for (int i = 0; i < BYTES; i++)
                if (w_strb[i]) mem[aw_idx[IW-1:0]][8*i +: 8] <= w_data[8*i +: 8];
    end

    always_comb begin
        arready = state_q == R_IDLE;
        rvalid  = state_q == R_RESP;
        // A commit owns the single array port, so the read access retries next cycle.
        state_d = state_q == R_IDLE   ? (arvalid ? R_ACCESS : R_IDLE) :
                  state_q == R_ACCESS ? (commit  ? R_ACCESS : R_RESP) :
                                        (rready  ? R_IDLE   : R_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= R_IDLE;
            ar_addr <= '0;
            rdata   <= '0;
            rresp   <= 2'b00;
        end else begin
            state_q <= state_d;
            if (arvalid && arready) ar_addr <= araddr;
            if (state_q == R_ACCESS && !commit) begin
                rdata <= ar_ok ? mem[ar_idx[IW-1:0]] : '0;
                rresp <= ar_ok ? 2'b00 : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_axil_sram_slave.sv
// tb_axil_sram_slave: randomized and directed checks of axil_sram_slave against a word-array model
module tb_axil_sram_slave;
    logic        clk, rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [9:0]  awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [31:0] mdl [64];
    int          n_pass, n_total;

    axil_sram_slave #(.ADDR_W(10), .DATA_W(32), .DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [1:0] resp_of(input logic [9:0] a);
        return (a >> 2) < 64 ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] data_of(input logic [9:0] a);
        int idx = int'(a >> 2);
        return idx < 64 ? mdl[idx] : 32'h0;
    endfunction

    task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int ad, input int wd);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int c = 0;
        int idx = int'(a >> 2);
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        while (!(aw_done && w_done) && c < 100) begin
            awvalid = !aw_done && c >= ad;
            wvalid  = !w_done && c >= wd;
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            tick();
            aw_done |= aw_hs;
            w_done  |= w_hs;
            c++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (c >= 100) check("aw_w_timeout", 0, 1);
        if (idx < 64)
            for (int i = 0; i < 4; i++)
                if (s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic wait_b(input logic [1:0] er, output int lat);
        lat = 0;
        while (!bvalid && lat < 50) begin
            tick();
            lat++;
        end
        check("bvalid_seen", bvalid, 1);
        check("bresp", bresp, er);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
    endtask

    task automatic axi_read(input logic [9:0] a, output int lat);
        bit hs;
        int c = 0;
        arvalid = 1'b1;
        araddr  = a;
        while (c < 50) begin
            hs = arready;
            tick();
            c++;
            if (hs) break;
        end
        arvalid = 1'b0;
        if (c >= 50) check("ar_timeout", 0, 1);
        lat = 0;
        while (!rvalid && lat < 50) begin
            tick();
            lat++;
        end
        check("rvalid_seen", rvalid, 1);
        check("rdata", rdata, data_of(a));
        check("rresp", rresp, resp_of(a));
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid_clear", rvalid, 0);
    endtask

    initial begin
        int lat, lat2;
        logic [9:0]  a;
        logic [31:0] d;
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        {awvalid, wvalid, bready, arvalid, rready} = '0;
        awaddr = '0;
        araddr = '0;
        wdata = '0;
        wstrb = '0;
        #2;
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rel_awready", awready, 1);
        check("rel_wready", wready, 1);
        check("rel_arready", arready, 1);

        for (int i = 0; i < 64; i++) begin
            axi_write(10'(i * 4), $urandom, 4'hF, 0, 0);
            wait_b(2'b00, lat);
        end

        axi_write(10'h004, 32'hDEADBEEF, 4'hF, 0, 0);
        wait_b(2'b00, lat);
        check("wr_latency", lat, 1);
        axi_read(10'h004, lat);
        check("rd_latency", lat, 1);
        check("rd_deadbeef", rdata, 32'hDEADBEEF);

        axi_write(10'h008, 32'h11223344, 4'hF, 2, 0);
        wait_b(2'b00, lat);
        axi_write(10'h008, 32'hAAAABBBB, 4'h3, 0, 0);
        wait_b(2'b00, lat);
        axi_read(10'h008, lat);
        check("rd_strb_merge", rdata, 32'h1122BBBB);

        axi_write(10'h0FC, 32'hCAFEF00D, 4'hF, 0, 0);
        wait_b(2'b00, lat);
        axi_write(10'h100, 32'h12345678, 4'hF, 0, 0);
        wait_b(2'b10, lat);
        axi_read(10'h100, lat);
        axi_read(10'h0FC, lat);
        check("rd_word63", rdata, 32'hCAFEF00D);
        axi_read(10'h000, lat);

        axi_write(10'h200, 32'h0BAD0BAD, 4'hF, 0, 0);
        lat = 0;
        while (!bvalid && lat < 50) begin
            tick();
            lat++;
        end
        axi_write(10'h00C, 32'h5A5A5A5A, 4'hF, 0, 0);
        check("stall_awready", awready, 0);
        check("stall_wready", wready, 0);
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid", bvalid, 1);
            check("stall_bresp", bresp, 2'b10);
            tick();
        end
        wait_b(2'b10, lat);
        check("first_b_lat", lat, 0);
        wait_b(2'b00, lat);
        check("second_b_lat", lat, 1);
        axi_read(10'h00C, lat);

        d = ~mdl[5];
        fork
            begin
                axi_write(10'h014, d, 4'hF, 0, 0);
                wait_b(2'b00, lat);
            end
            axi_read(10'h014, lat2);
        join
        check("collide_rd_lat", lat2, 2);
        check("collide_rd_new", rdata, d);

        for (int n = 0; n < 200; n++) begin
            a = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(256, 1023)) : 10'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
                wait_b(resp_of(a), lat);
                check("rand_wr_lat", lat, 1);
            end else begin
                axi_read(a, lat);
                check("rand_rd_lat", lat, 1);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        arvalid = 1'b1;
        araddr = 10'h004;
        tick();
        arvalid = 1'b0;
        tick();
        check("pre_rst_rvalid", rvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rvalid", rvalid, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_arready", arready, 1);
        check("post_rst_awready", awready, 1);
        check("post_rst_wready", wready, 1);
        for (int i = 0; i < 4; i++) begin
            check("post_rst_rvalid", rvalid, 0);
            check("post_rst_bvalid", bvalid, 0);
            tick();
        end
        axi_write(10'h010, 32'h600DF00D, 4'hF, 0, 0);
        wait_b(2'b00, lat);
        axi_read(10'h010, lat);
        check("post_rst_rd", rdata, 32'h600DF00D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axil_sram_slave.md
AXIL_SRAM_SLAVE -- requirements
Module: axil_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values 32 or 64.
REQ-003 SHALL have parameter DEPTH, default 64, number of DATA_W words; DEPTH*DATA_W/8 <= 2**ADDR_W.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports awvalid in 1, awready out 1, awaddr in ADDR_W  write-address channel.
REQ-007 SHALL have ports wvalid in 1, wready out 1, wdata in DATA_W, wstrb in DATA_W/8  write-data channel.
REQ-008 SHALL have ports bvalid out 1, bready in 1, bresp out 2  write-response channel.
REQ-009 SHALL have ports arvalid in 1, arready out 1, araddr in ADDR_W  read-address channel.
REQ-010 SHALL have ports rvalid out 1, rready in 1, rdata out DATA_W, rresp out 2  read-data channel.

Function
REQ-011 SHALL store data in an internal single-port array of DEPTH x DATA_W; one access (read or write) per cycle.
REQ-012 SHALL form word index = addr >> log2(DATA_W/8); low byte-offset bits ignored.
REQ-013 SHALL treat word index >= DEPTH as out of range: response 2'b10 (SLVERR), no array write, rdata all zeros; in-range response 2'b00 (OKAY).
REQ-014 SHALL hold AW and W in independent one-entry buffers; awready = AW buffer empty, wready = W buffer empty; AW and W may arrive in any order or the same cycle.
REQ-015 SHALL commit a write in any cycle where both buffers are full and bvalid is 0; commit updates only bytes with wstrb bit set, empties both buffers, and asserts bvalid with bresp the next cycle.
REQ-016 SHALL hold bvalid and bresp stable until bready is sampled high; bvalid deasserts the cycle after handshake; bvalid and bready both high in the same cycle as a new commit condition: the commit waits one cycle.
REQ-017 SHALL let buffers accept a new AW/W while bvalid is pending; the next commit waits until B handshake completes.
REQ-018 SHALL implement read FSM states R_IDLE, R_ACCESS, R_RESP; arready = 1 only in R_IDLE.
REQ-019 SHALL in R_IDLE on arvalid latch araddr, go to R_ACCESS.
REQ-020 SHALL in R_ACCESS perform the array read and go to R_RESP, unless a write commits that cycle (write priority), in which case remain in R_ACCESS.
REQ-021 SHALL in R_RESP drive rvalid = 1 with rdata/rresp stable; on rready go to R_IDLE.
REQ-022 SHALL give minimum read latency: AR handshake cycle N -> rvalid high at N+2; minimum write latency: AW+W handshake cycle N -> bvalid high at N+2.
REQ-023 SHALL return newly written data for a read whose array access follows a commit to the same word (no stale data).
REQ-024 SHALL never drop or reorder transactions; one outstanding read and one outstanding write response max.

Reset
REQ-025 SHALL on rst asynchronously clear both buffers, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, read FSM to R_IDLE; awready=wready=arready=1 after reset releases.
REQ-026 SHALL leave array contents undefined after reset; rst asserted mid-transaction aborts it with no response issued; a commit in the reset cycle is not guaranteed.

Verification
REQ-027 SHALL pass: AW addr 0x04 + W 0xDEADBEEF strb 0xF same cycle, bready=1 -> bvalid at +2 cycles, bresp 00; then AR 0x04 -> rdata 0xDEADBEEF, rresp 00 at +2.
REQ-028 SHALL pass: W 0x11223344 two cycles before AW 0x08, then strb 0x3 write 0xAAAABBBB -> read 0x08 returns 0x1122BBBB.
REQ-029 SHALL pass: AW 0xFC (word 63 ok) vs AW 0x100-equivalent out of range with ADDR_W=10 addr 0x100 -> bresp 10, read returns rdata 0, rresp 10, array unchanged.
REQ-030 SHALL pass: bready held low 5 cycles -> bvalid/bresp stable; second AW/W accepted, awready then 0; second bvalid follows first handshake.
REQ-031 SHALL pass: write commit and R_ACCESS same cycle to same word -> read stalls one cycle, returns new data.
REQ-032 SHALL pass: rst pulsed while rvalid=1, rready=0 -> rvalid=0 immediately, arready=1 after release, no spurious response.
